// File: rtl/quic_enc_golomb_pack.sv
// Golomb-Rice / fixed-length codeword packer: builds MSB-first 32-bit words
// from per-symbol codewords, with a flush path that zero-pads a partial word.
module quic_enc_golomb_pack #(
    parameter int MAX_CWLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [7:0]  symbol,
    input  logic [2:0]  bestcode,
    input  logic [31:0] nGRcodewords_i,
    input  logic [5:0]  notGRcwlen_i,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_data,
    output logic [31:0] words_out,
    output logic        cw_err
);

    // state     | meaning
    // RUN       | accepting symbols, emitting full words
    // FLUSH_PAD | draining full words, then padding the partial word to 32 bits
    // FLUSH_OUT | waiting for the padded word to be taken
    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_FLUSH_PAD = 2'd1;
    localparam logic [1:0] ST_FLUSH_OUT = 2'd2;

    localparam logic [8:0] LP_MAX_LEN = 9'(MAX_CWLEN);

    logic [63:0] r_acc;
    logic [6:0]  r_fill;
    logic [1:0]  r_state;
    logic [31:0] r_words_out;
    logic        r_cw_err;
    logic        r_flush_done;

    logic        w_is_gr;
    logic [8:0]  w_gr_len;
    logic [31:0] w_gr_cw;
    logic [31:0] w_ngr_cw;
    logic [8:0]  w_len;
    logic [31:0] w_cw;
    logic [31:0] w_mask;
    logic        w_len_bad;
    logic [6:0]  w_shamt;
    logic [63:0] w_ins;
    logic        w_accept;
    logic        w_handoff;

    assign w_is_gr  = {24'd0, symbol} < nGRcodewords_i;
    assign w_gr_len = ({1'b0, symbol} >> bestcode) + {6'd0, bestcode} + 9'd1;
    assign w_gr_cw  = (32'd1 << bestcode) | ({24'd0, symbol} & ((32'd1 << bestcode) - 32'd1));
    assign w_ngr_cw = {24'd0, symbol} - nGRcodewords_i;

    assign w_len     = w_is_gr ? w_gr_len : {3'd0, notGRcwlen_i};
    assign w_cw      = w_is_gr ? w_gr_cw : w_ngr_cw;
    assign w_len_bad = (w_len == 9'd0) || (w_len > LP_MAX_LEN);
    assign w_mask    = (w_len >= 9'd32) ? 32'hFFFF_FFFF : ((32'd1 << w_len[4:0]) - 32'd1);

    // Only meaningful for a legal accept: fill < 32 and length 1..32 keep this in 1..63.
    assign w_shamt = 7'd64 - r_fill - w_len[6:0];
    assign w_ins   = {32'd0, w_cw & w_mask} << w_shamt;

    assign sym_ready  = (r_fill < 7'd32) && (r_state == ST_RUN);
    assign word_valid = (r_fill >= 7'd32);
    assign word_data  = r_acc[63:32];
    assign words_out  = r_words_out;
    assign cw_err     = r_cw_err;
    assign flush_done = r_flush_done;

    assign w_accept  = sym_valid && sym_ready;
    assign w_handoff = word_valid && word_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc        <= 64'd0;
            r_fill       <= 7'd0;
            r_state      <= ST_RUN;
            r_words_out  <= 32'd0;
            r_cw_err     <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;

            // Accept and handoff are mutually exclusive: one needs fill < 32, the other fill >= 32.
            if (w_accept) begin
                if (w_len_bad) begin
                    r_cw_err <= 1'b1;
                end else begin
                    r_acc  <= r_acc | w_ins;
                    r_fill <= r_fill + w_len[6:0];
                end
            end else if (w_handoff) begin
                r_acc       <= {r_acc[31:0], 32'd0};
                r_fill      <= r_fill - 7'd32;
                r_words_out <= r_words_out + 32'd1;
            end

            case (r_state)
                ST_RUN: begin
                    if (flush_req) r_state <= ST_FLUSH_PAD;
                end
                ST_FLUSH_PAD: begin
                    if (r_fill < 7'd32) begin
                        if (r_fill == 7'd0) begin
                            r_state      <= ST_RUN;
                            r_flush_done <= 1'b1;
                        end else begin
                            // Unused accumulator bits are already zero, so this is the padding.
                            r_fill  <= 7'd32;
                            r_state <= ST_FLUSH_OUT;
                        end
                    end
                end
                ST_FLUSH_OUT: begin
                    if (w_handoff) begin
                        r_state      <= ST_RUN;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule
